// File: rtl/branch_resolve_unit.sv
// Branch-resolution stage: evaluates conditional branches, CALL/RET via a return stack,
// and produces a registered branch target plus a fetch-squash (flush) window.
module branch_resolve_unit #(
    parameter int ADDR_W       = 8,
    parameter int NUM_ACC      = 2,
    parameter int STACK_DEPTH  = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         iValid,
    input  logic [15:0]                  iInstruction,
    input  logic [ADDR_W-1:0]            iReturn_pc,
    input  logic [NUM_ACC-1:0]           iZ,
    input  logic [NUM_ACC-1:0]           iC,
    input  logic [NUM_ACC-1:0]           iN,
    output logic                         oBranch_taken,
    output logic [ADDR_W-1:0]            oBranch_dir,
    output logic                         oFlush,
    output logic                         oIllegal,
    output logic                         oOverflow,
    output logic                         oUnderflow,
    output logic [$clog2(STACK_DEPTH):0] oDepth
);

    localparam int PTR_W   = $clog2(STACK_DEPTH);
    localparam int DEPTH_W = PTR_W + 1;

    localparam logic [DEPTH_W-1:0] FULL_DEPTH = DEPTH_W'(STACK_DEPTH);
    localparam logic [2:0]         ACC_LIMIT  = 3'(NUM_ACC);
    localparam logic [2:0]         FLUSH_LOAD = 3'(FLUSH_CYCLES);

    typedef enum logic {
        IDLE,
        FLUSH
    } state_t;

    state_t                 state;
    logic [2:0]             flush_cnt;
    logic [ADDR_W-1:0]      ret_stack [STACK_DEPTH];

    logic [3:0]             z_ext;
    logic [3:0]             c_ext;
    logic [3:0]             n_ext;
    logic [2:0]             cond;
    logic [1:0]             sel;
    logic                   accept;
    logic                   flag_ok;
    logic                   take;
    logic                   illegal;
    logic                   push;
    logic                   pop;
    logic                   ovf_evt;
    logic                   udf_evt;
    logic [ADDR_W-1:0]      target;
    logic [DEPTH_W-1:0]     depth_m1;

    // Flags widened to four accumulators so unselected slots read as zero
    always_comb begin
        z_ext = '0;
        c_ext = '0;
        n_ext = '0;
        z_ext[NUM_ACC-1:0] = iZ;
        c_ext[NUM_ACC-1:0] = iC;
        n_ext[NUM_ACC-1:0] = iN;
    end

    assign cond     = iInstruction[10:8];
    assign sel      = iInstruction[12:11];
    assign accept   = iValid && (iInstruction[15:13] == 3'b111) && (state == IDLE);
    assign depth_m1 = oDepth - 1'b1;

    always_comb begin
        take    = 1'b0;
        illegal = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        ovf_evt = 1'b0;
        udf_evt = 1'b0;
        flag_ok = 1'b0;
        target  = iInstruction[ADDR_W-1:0];
        if (accept) begin
            case (cond)
                3'b110: take = 1'b1;
                3'b111: begin
                    if (!iInstruction[12]) begin
                        // A CALL on a full stack still jumps; only the return address is lost
                        take = 1'b1;
                        if (oDepth < FULL_DEPTH) push = 1'b1;
                        else                     ovf_evt = 1'b1;
                    end else if (oDepth != '0) begin
                        take   = 1'b1;
                        pop    = 1'b1;
                        target = ret_stack[depth_m1[PTR_W-1:0]];
                    end else begin
                        udf_evt = 1'b1;
                    end
                end
                default: begin
                    if ({1'b0, sel} >= ACC_LIMIT) begin
                        illegal = 1'b1;
                    end else begin
                        case (cond)
                            3'b000:  flag_ok =  z_ext[sel];
                            3'b001:  flag_ok = ~z_ext[sel];
                            3'b010:  flag_ok =  c_ext[sel];
                            3'b011:  flag_ok = ~c_ext[sel];
                            3'b100:  flag_ok =  n_ext[sel];
                            default: flag_ok = ~n_ext[sel];
                        endcase
                        take = flag_ok;
                    end
                end
            endcase
        end
    end

    // Stack storage needs no reset; occupancy alone defines what is valid
    always_ff @(posedge Clock) begin
        if (push) ret_stack[oDepth[PTR_W-1:0]] <= iReturn_pc;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state         <= IDLE;
            flush_cnt     <= '0;
            oBranch_taken <= 1'b0;
            oBranch_dir   <= '0;
            oFlush        <= 1'b0;
            oIllegal      <= 1'b0;
            oOverflow     <= 1'b0;
            oUnderflow    <= 1'b0;
            oDepth        <= '0;
        end else begin
            oBranch_taken <= take;
            oIllegal      <= illegal;
            if (take)    oBranch_dir <= target;
            if (ovf_evt) oOverflow   <= 1'b1;
            if (udf_evt) oUnderflow  <= 1'b1;
            if (push)     oDepth <= oDepth + 1'b1;
            else if (pop) oDepth <= oDepth - 1'b1;

            case (state)
                IDLE: begin
                    if (take) begin
                        state     <= FLUSH;
                        flush_cnt <= FLUSH_LOAD;
                        oFlush    <= 1'b1;
                    end
                end
                default: begin
                    if (flush_cnt == 3'd1) begin
                        state  <= IDLE;
                        oFlush <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus randomized
// instruction streams compared against a queue-based behavioural model.
module tb_branch_resolve_unit;

    localparam int ADDR_W       = 8;
    localparam int NUM_ACC      = 2;
    localparam int STACK_DEPTH  = 4;
    localparam int FLUSH_CYCLES = 2;
    localparam int DEPTH_W      = $clog2(STACK_DEPTH) + 1;
    localparam int VW           = ADDR_W + 5 + DEPTH_W;

    logic                Clock;
    logic                Reset;
    logic                iValid;
    logic [15:0]         iInstruction;
    logic [ADDR_W-1:0]   iReturn_pc;
    logic [NUM_ACC-1:0]  iZ;
    logic [NUM_ACC-1:0]  iC;
    logic [NUM_ACC-1:0]  iN;
    logic                oBranch_taken;
    logic [ADDR_W-1:0]   oBranch_dir;
    logic                oFlush;
    logic                oIllegal;
    logic                oOverflow;
    logic                oUnderflow;
    logic [DEPTH_W-1:0]  oDepth;

    int vectors;
    int miscompares;

    // Behavioural model state
    logic [ADDR_W-1:0]   model_stack[$];
    int                  flush_left;
    logic                exp_taken;
    logic [ADDR_W-1:0]   exp_dir;
    logic                exp_illegal;
    logic                exp_ovf;
    logic                exp_udf;

    branch_resolve_unit #(
        .ADDR_W(ADDR_W),
        .NUM_ACC(NUM_ACC),
        .STACK_DEPTH(STACK_DEPTH),
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .iValid(iValid),
        .iInstruction(iInstruction),
        .iReturn_pc(iReturn_pc),
        .iZ(iZ),
        .iC(iC),
        .iN(iN),
        .oBranch_taken(oBranch_taken),
        .oBranch_dir(oBranch_dir),
        .oFlush(oFlush),
        .oIllegal(oIllegal),
        .oOverflow(oOverflow),
        .oUnderflow(oUnderflow),
        .oDepth(oDepth)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [VW-1:0] obs();
        return {oBranch_taken, oBranch_dir, oFlush, oIllegal, oOverflow, oUnderflow, oDepth};
    endfunction

    function automatic logic [VW-1:0] expv();
        return {exp_taken, exp_dir, (flush_left > 0), exp_illegal, exp_ovf, exp_udf,
                DEPTH_W'(model_stack.size())};
    endfunction

    task automatic model_reset();
        model_stack.delete();
        flush_left  = 0;
        exp_taken   = 1'b0;
        exp_dir     = '0;
        exp_illegal = 1'b0;
        exp_ovf     = 1'b0;
        exp_udf     = 1'b0;
    endtask

    task automatic model_take(input logic [ADDR_W-1:0] t);
        exp_taken  = 1'b1;
        exp_dir    = t;
        flush_left = FLUSH_CYCLES;
    endtask

    // One clock edge of the architectural behaviour, from the instruction-set rules
    task automatic model_edge();
        int  a;
        int  cond;
        bit  hit;
        exp_taken   = 1'b0;
        exp_illegal = 1'b0;
        if (flush_left > 0) begin
            flush_left--;
        end else if (iValid && iInstruction[15:13] == 3'b111) begin
            cond = int'(iInstruction[10:8]);
            a    = int'(iInstruction[12:11]);
            if (cond <= 5) begin
                if (a >= NUM_ACC) begin
                    exp_illegal = 1'b1;
                end else begin
                    case (cond)
                        0: hit = (iZ[a] == 1'b1);
                        1: hit = (iZ[a] == 1'b0);
                        2: hit = (iC[a] == 1'b1);
                        3: hit = (iC[a] == 1'b0);
                        4: hit = (iN[a] == 1'b1);
                        default: hit = (iN[a] == 1'b0);
                    endcase
                    if (hit) model_take(iInstruction[ADDR_W-1:0]);
                end
            end else if (cond == 6) begin
                model_take(iInstruction[ADDR_W-1:0]);
            end else if (!iInstruction[12]) begin
                model_take(iInstruction[ADDR_W-1:0]);
                if (model_stack.size() < STACK_DEPTH) model_stack.push_back(iReturn_pc);
                else exp_ovf = 1'b1;
            end else if (model_stack.size() > 0) begin
                model_take(model_stack.pop_back());
            end else begin
                exp_udf = 1'b1;
            end
        end
    endtask

    task automatic step(input logic v, input logic [15:0] ins, input logic [ADDR_W-1:0] rp,
                        input logic [NUM_ACC-1:0] zz, input logic [NUM_ACC-1:0] cc,
                        input logic [NUM_ACC-1:0] nn);
        iValid       = v;
        iInstruction = ins;
        iReturn_pc   = rp;
        iZ           = zz;
        iC           = cc;
        iN           = nn;
        @(posedge Clock);
        model_edge();
        @(negedge Clock);
    endtask

    task automatic idle();
        step(1'b0, 16'h0000, '0, '0, '0, '0);
    endtask

    task automatic apply_reset();
        @(negedge Clock);
        iValid = 1'b0;
        Reset  = 1'b0;
        model_reset();
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge Clock);
        Reset        = 1'b0;
        iValid       = 1'b1;
        iInstruction = 16'hFFFF;
        iReturn_pc   = '1;
        iZ           = '1;
        iC           = '1;
        iN           = '1;
        model_reset();
        #1;
        vectors++;
        if (obs() !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got %h expected %h", obs(), {VW{1'b0}});
        end
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            idle();
            vectors++;
            if (obs() !== '0) begin
                miscompares++;
                $display("[TB] FAIL reset_idle%0d: got %h expected %h", i, obs(), {VW{1'b0}});
            end
        end
    endtask

    task automatic test_conditions();
        logic [15:0]        ins [6];
        logic [NUM_ACC-1:0] zv  [6];
        logic [NUM_ACC-1:0] cv  [6];
        logic [VW-1:0]      m;
        apply_reset();
        ins[0] = 16'hE005; zv[0] = 2'b01; cv[0] = 2'b00;
        ins[1] = 16'hE005; zv[1] = 2'b00; cv[1] = 2'b00;
        ins[2] = 16'hE912; zv[2] = 2'b00; cv[2] = 2'b01;
        ins[3] = 16'hE912; zv[3] = 2'b00; cv[3] = 2'b10;
        ins[4] = 16'hF033; zv[4] = 2'b11; cv[4] = 2'b00;
        ins[5] = 16'hE634; zv[5] = 2'b00; cv[5] = 2'b00;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, ins[i], 8'h00, zv[i], cv[i], 2'b00);
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("[TB] FAIL cond%0d: got %h expected %h", i, obs(), expv());
            end
            for (int k = 0; k < FLUSH_CYCLES + 1; k++) begin
                m = expv();
                idle();
                vectors++;
                if (obs() !== expv()) begin
                    miscompares++;
                    $display("[TB] FAIL cond%0d_tail%0d: got %h expected %h", i, k, obs(), expv());
                end
            end
            if (i == 3) begin
                vectors++;
                if (oBranch_dir !== 8'h12) begin
                    miscompares++;
                    $display("[TB] FAIL cc_dir_held: got %h expected %h", oBranch_dir, 8'h12);
                end
            end
        end
        // Illegal accumulator select produces exactly one pulse
        step(1'b1, 16'hF005, 8'h00, 2'b11, 2'b11, 2'b11);
        vectors++;
        if ({oIllegal, oBranch_taken, oFlush} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL illegal_pulse: got %b expected %b", {oIllegal, oBranch_taken, oFlush}, 3'b100);
        end
        idle();
        vectors++;
        if (oIllegal !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL illegal_clear: got %b expected %b", oIllegal, 1'b0);
        end
    endtask

    task automatic test_call_ret();
        logic [ADDR_W-1:0] dirs [2];
        logic [DEPTH_W-1:0] deps [2];
        apply_reset();
        dirs[0] = 8'h40; deps[0] = 1;
        dirs[1] = 8'h21; deps[1] = 0;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, (i == 0) ? 16'hE740 : 16'hF700, 8'h21, '0, '0, '0);
            vectors++;
            if ({oBranch_taken, oBranch_dir, oDepth} !== {1'b1, dirs[i], deps[i]} || obs() !== expv()) begin
                miscompares++;
                $display("[TB] FAIL call_ret%0d: got %h expected %h", i, obs(), expv());
            end
            repeat (FLUSH_CYCLES) idle();
        end
    endtask

    task automatic test_stack_limits();
        int taken_cnt;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 16'hE780 | 16'(i), 8'(8'h10 + i), '0, '0, '0);
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("[TB] FAIL push%0d: got %h expected %h", i, obs(), expv());
            end
            repeat (FLUSH_CYCLES) idle();
        end
        vectors++;
        if ({oOverflow, oDepth} !== {1'b1, DEPTH_W'(4)}) begin
            miscompares++;
            $display("[TB] FAIL overflow_full: got %h expected %h", {oOverflow, oDepth}, {1'b1, DEPTH_W'(4)});
        end
        taken_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 16'hFF00, 8'h00, '0, '0, '0);
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("[TB] FAIL pop%0d: got %h expected %h", i, obs(), expv());
            end
            if (oBranch_taken) taken_cnt++;
            repeat (FLUSH_CYCLES) idle();
        end
        vectors++;
        if ({taken_cnt, oUnderflow, oOverflow} !== {32'd4, 1'b1, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL underflow: got taken=%0d udf=%b ovf=%b expected taken=4 udf=1 ovf=1",
                     taken_cnt, oUnderflow, oOverflow);
        end
    endtask

    task automatic test_flush_discard();
        apply_reset();
        step(1'b1, 16'hE710, 8'h33, '0, '0, '0);
        repeat (FLUSH_CYCLES) idle();
        step(1'b1, 16'hE6AA, 8'h00, '0, '0, '0);
        for (int i = 0; i < FLUSH_CYCLES; i++) begin
            step(1'b1, 16'hE750, 8'h44, '0, '0, '0);
            vectors++;
            if (obs() !== expv() || oDepth !== DEPTH_W'(1) || oBranch_dir !== 8'hAA) begin
                miscompares++;
                $display("[TB] FAIL discard%0d: got %h expected %h", i, obs(), expv());
            end
        end
        // Reset mid-flush must clear the window and empty the stack at once
        step(1'b1, 16'hE760, 8'h55, '0, '0, '0);
        #2;
        Reset = 1'b0;
        model_reset();
        #1;
        vectors++;
        if ({oFlush, oDepth, oBranch_taken} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_flush: got flush=%b depth=%0d expected 0/0", oFlush, oDepth);
        end
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    task automatic test_random();
        logic [15:0] ins;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            ins = 16'($urandom);
            if ($urandom_range(0, 9) < 8) ins[15:13] = 3'b111;
            step(($urandom_range(0, 3) != 0), ins, ADDR_W'($urandom),
                 NUM_ACC'($urandom), NUM_ACC'($urandom), NUM_ACC'($urandom));
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("[TB] FAIL random%0d ins=%h: got %h expected %h", i, ins, obs(), expv());
            end
            if ($urandom_range(0, 99) == 0) apply_reset();
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        Reset        = 1'b0;
        iValid       = 1'b0;
        iInstruction = '0;
        iReturn_pc   = '0;
        iZ           = '0;
        iC           = '0;
        iN           = '0;
        model_reset();
        test_reset();
        test_conditions();
        test_call_ret();
        test_stack_limits();
        test_flush_discard();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
